// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline package: fetch FSM states, NOP encoding and instruction field positions.
package cpu_pipe_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        SQUASH
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    localparam int unsigned RN_LSB = 16;
    localparam int unsigned RD_LSB = 12;
    localparam int unsigned RM_LSB = 0;

    function automatic logic [3:0] instr_rn(input logic [31:0] instr);
        return instr[RN_LSB +: 4];
    endfunction

    function automatic logic [3:0] instr_rd(input logic [31:0] instr);
        return instr[RD_LSB +: 4];
    endfunction

    function automatic logic [3:0] instr_rm(input logic [31:0] instr);
        return instr[RM_LSB +: 4];
    endfunction

endpackage

// File: rtl/if_id_fetch_unit_if.sv
// Fetch-side bus: hazard controls, branch redirect, instruction memory and IF/ID outputs.
interface if_id_fetch_unit_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32
);
    logic               LE_PC;
    logic               LE_IF_ID;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_target;
    logic [INSTR_W-1:0] imem_data;
    logic [ADDR_W-1:0]  pc_out;
    logic [INSTR_W-1:0] id_instr;
    logic [ADDR_W-1:0]  id_pc_next;
    logic               id_valid;

    modport master (
        input  LE_PC, LE_IF_ID, branch_taken, branch_target, imem_data,
        output pc_out, id_instr, id_pc_next, id_valid
    );

    modport slave (
        output LE_PC, LE_IF_ID, branch_taken, branch_target, imem_data,
        input  pc_out, id_instr, id_pc_next, id_valid
    );
endinterface

// File: rtl/if_id_fetch_unit_if_id_reg.sv
// Pipeline register with load enable and synchronous clear to a bubble (clear beats load).
module if_id_reg
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] instr_d,
    input  logic [ADDR_W-1:0]  pc_next_d,
    input  logic               valid_d,
    output logic [INSTR_W-1:0] instr_q,
    output logic [ADDR_W-1:0]  pc_next_q,
    output logic               valid_q
);
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            instr_q   <= INSTR_W'(NOP_INSTR);
            pc_next_q <= '0;
            valid_q   <= 1'b0;
        end else if (load) begin
            instr_q   <= instr_d;
            pc_next_q <= pc_next_d;
            valid_q   <= valid_d;
        end
    end
endmodule

// File: rtl/if_id_fetch_unit.sv
// Fetch stage: PC register, sequential adder, boot/squash FSM and IF/ID register.
// Optional perf counters (stall_cycles, squash_count) when FETCH_PERF_CNT_EN is defined.
module if_id_fetch_unit
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    if_id_fetch_unit_if.master      bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]             stall_cycles,
    output logic [15:0]             squash_count
`endif
);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    fetch_state_t       state, state_nx;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_seq;
    logic               branch_accept;
    logic               ifid_clear;
    logic [INSTR_W-1:0] ifid_instr;
    logic [ADDR_W-1:0]  ifid_pc_next;
    logic               ifid_valid;

    assign pc_seq = pc + STEP;

    // Stalled cycles must not redirect: ID re-presents the branch once the stall lifts.
    assign branch_accept = bus.branch_taken && bus.LE_PC && bus.LE_IF_ID && ifid_valid;

    always_ff @(posedge clk) begin
        if (reset) state <= BOOT;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        ifid_clear = branch_accept;
        unique case (state)
            BOOT: begin
                ifid_clear = bus.LE_IF_ID;
                if (bus.LE_PC) state_nx = RUN;
            end
            RUN: begin
                if (branch_accept) state_nx = SQUASH;
            end
            SQUASH: begin
                state_nx = branch_accept ? SQUASH : RUN;
            end
            default: state_nx = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)              pc <= RESET_PC;
        else if (branch_accept) pc <= bus.branch_target;
        else if (bus.LE_PC)     pc <= pc_seq;
    end

    if_id_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (bus.LE_IF_ID),
        .clear     (ifid_clear),
        .instr_d   (bus.imem_data),
        .pc_next_d (pc_seq),
        .valid_d   (1'b1),
        .instr_q   (ifid_instr),
        .pc_next_q (ifid_pc_next),
        .valid_q   (ifid_valid)
    );

    assign bus.pc_out     = pc;
    assign bus.id_instr   = ifid_instr;
    assign bus.id_pc_next = ifid_pc_next;
    assign bus.id_valid   = ifid_valid;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            squash_count <= '0;
        end else begin
            if (!bus.LE_PC && state != BOOT && stall_cycles != '1)
                stall_cycles <= stall_cycles + 16'd1;
            if (branch_accept && squash_count != '1)
                squash_count <= squash_count + 16'd1;
        end
    end
`endif
endmodule
